// File: rtl/demux_ctrl_pkg.sv
// Shared types, constants and the select decoder for the demux dispatcher.
// Pure declarations: no state, no latency, no flow control.
package demux_ctrl_pkg;

   typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

   localparam int DEMUX_CNT_W = 8;

   // Out-of-range selects decode to all-zero, which is how callers spot a bad sel.
   function automatic logic [15:0] onehot(input logic [3:0] sel, input int n);
      logic [15:0] v;
      v = '0;
      for (int i = 0; i < 16; i++)
         if (i < n && sel == i[3:0]) v[i] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/demux_stall_timer.sv
// Saturating stall counter: expire is high once TIMEOUT-1 stalled cycles have been counted.
// Latency: clr/inc take effect at the next edge; no flow control.
module demux_stall_timer
   import demux_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   output logic expire
);

   localparam logic [DEMUX_CNT_W-1:0] LAST = DEMUX_CNT_W'(TIMEOUT - 1);

   logic [DEMUX_CNT_W-1:0] wait_cnt;

   assign expire = (wait_cnt == LAST);

   always_ff @(posedge clk) begin
      if (!rst_n || clr)
         wait_cnt <= '0;
      else if (inc && wait_cnt != LAST)
         wait_cnt <= wait_cnt + DEMUX_CNT_W'(1);
   end

endmodule

// File: rtl/demux_dispatcher.sv
// 1-to-N_OUT dispatcher with a one-word buffer; dout_valid 1 cycle after accept, 1 word/cycle streaming.
// Backpressure: din_ready follows the selected sink's ready while holding; a stalled word drops after TIMEOUT cycles.
// DEMUX_STATS_EN adds per-channel transfer counters and a saturating drop counter.
module demux_dispatcher
   import demux_ctrl_pkg::*;
#(
   parameter int N_OUT   = 4,
   parameter int DW      = 8,
   parameter int SW      = $clog2(N_OUT),
   parameter int TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [DW-1:0]    din,
   input  logic             din_valid,
   input  logic [SW-1:0]    sel,
   output logic             din_ready,
   output logic [DW-1:0]    dout,
   output logic [N_OUT-1:0] dout_valid,
   input  logic [N_OUT-1:0] dout_ready,
   output logic             drop,
   output logic             busy
`ifdef DEMUX_STATS_EN
   ,
   output logic [N_OUT*DEMUX_CNT_W-1:0] xfer_cnt,
   output logic [DEMUX_CNT_W-1:0]       drop_cnt
`endif
);

   state_t           state;
   logic [SW-1:0]    sel_q;
   logic [N_OUT-1:0] hold_oh;
   logic             good_sel;
   logic             xfer;
   logic             accept;
   logic             load;
   logic             bad;
   logic             expire;

   assign good_sel   = |onehot(4'(sel), N_OUT);
   assign hold_oh    = N_OUT'(onehot(4'(sel_q), N_OUT));
   assign busy       = (state == HOLD);
   assign dout_valid = busy ? hold_oh : '0;
   assign xfer       = |(dout_valid & dout_ready);
   // Unselected sinks cannot influence din_ready: only the held channel's ready matters.
   assign din_ready  = ~busy | xfer;
   assign accept     = din_valid & din_ready;
   assign load       = accept & good_sel;
   assign bad        = accept & ~good_sel;

   demux_stall_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (load | ~busy),
      .inc    (busy & ~xfer),
      .expire (expire)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         dout  <= '0;
         sel_q <= '0;
         drop  <= 1'b0;
      end else begin
         drop <= bad | (busy & ~xfer & expire);
         case (state)
            IDLE: begin
               if (load) begin
                  dout  <= din;
                  sel_q <= sel;
                  state <= HOLD;
               end
            end
            HOLD: begin
               if (xfer) begin
                  if (load) begin
                     dout  <= din;
                     sel_q <= sel;
                  end else begin
                     state <= IDLE;
                  end
               end else if (expire) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef DEMUX_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         xfer_cnt <= '0;
         drop_cnt <= '0;
      end else begin
         for (int i = 0; i < N_OUT; i++)
            if (xfer && hold_oh[i])
               xfer_cnt[i*DEMUX_CNT_W +: DEMUX_CNT_W] <=
                  xfer_cnt[i*DEMUX_CNT_W +: DEMUX_CNT_W] + DEMUX_CNT_W'(1);
         if (drop && drop_cnt != '1)
            drop_cnt <= drop_cnt + DEMUX_CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_demux_dispatcher.sv
// Scoreboard bench for demux_dispatcher: a 4-channel instance for the main traffic and a
// 3-channel instance for out-of-range selects.
module tb_demux_dispatcher;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] din;
   logic       din_valid;
   logic [1:0] sel;
   logic       din_ready;
   logic [7:0] dout;
   logic [3:0] dout_valid;
   logic [3:0] dout_ready;
   logic       drop;
   logic       busy;

   logic       din_valid3;
   logic [1:0] sel3;
   logic       din_ready3;
   logic [7:0] dout3;
   logic [2:0] dout_valid3;
   logic [2:0] dout_ready3;
   logic       drop3;
   logic       busy3;

`ifdef DEMUX_STATS_EN
   logic [31:0] xfer_cnt;
   logic [7:0]  drop_cnt;
   logic [23:0] xfer_cnt3;
   logic [7:0]  drop_cnt3;
`endif

   int         total = 0;
   int         bad   = 0;
   logic [9:0] sb[$];
   logic [9:0] mon_exp;

   always #5 clk = ~clk;

   demux_dispatcher #(.N_OUT(4), .DW(8), .TIMEOUT(15)) dut (
      .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sel(sel),
      .din_ready(din_ready), .dout(dout), .dout_valid(dout_valid),
      .dout_ready(dout_ready), .drop(drop), .busy(busy)
`ifdef DEMUX_STATS_EN
      , .xfer_cnt(xfer_cnt), .drop_cnt(drop_cnt)
`endif
   );

   demux_dispatcher #(.N_OUT(3), .DW(8), .TIMEOUT(15)) dut3 (
      .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid3), .sel(sel3),
      .din_ready(din_ready3), .dout(dout3), .dout_valid(dout_valid3),
      .dout_ready(dout_ready3), .drop(drop3), .busy(busy3)
`ifdef DEMUX_STATS_EN
      , .xfer_cnt(xfer_cnt3), .drop_cnt(drop_cnt3)
`endif
   );

   // Every output transfer must match the oldest word still owed.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && (dout_valid & dout_ready) != 4'b0) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL xfer_unexpected: dout=%h dout_valid=%b, no word owed", dout, dout_valid);
         end else begin
            mon_exp = sb.pop_front();
            if (dout !== mon_exp[7:0] || dout_valid !== (4'b0001 << mon_exp[9:8])) begin
               bad++;
               $display("FAIL xfer_word: got dout=%h valid=%b want dout=%h valid=%b",
                        dout, dout_valid, mon_exp[7:0], 4'b0001 << mon_exp[9:8]);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; din = 8'hFF; sel = 2'd1; din_valid = 1'b1; dout_ready = 4'b0000;
      din_valid3 = 1'b0; sel3 = 2'd0; dout_ready3 = 3'b000;
      tick(); tick();
      total++; if (dout_valid !== 4'b0000) begin bad++; $display("FAIL rst_valid: got %b want 0000", dout_valid); end
      total++; if (din_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", din_ready); end
      total++; if (dout !== 8'h00) begin bad++; $display("FAIL rst_dout: got %h want 00", dout); end
      total++; if (drop !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_drop_busy: got %b%b want 00", drop, busy); end
      rst_n = 1'b1; din_valid = 1'b0;
      tick();
      total++; if (dout_valid !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL rst_nocapture: got valid=%b busy=%b want 0000/0", dout_valid, busy); end
   endtask

   task automatic test_single();
      din = 8'hA5; sel = 2'd2; din_valid = 1'b1; dout_ready = 4'b0100;
      sb.push_back({2'd2, 8'hA5});
      tick();
      din_valid = 1'b0;
      total++; if (dout_valid !== 4'b0100) begin bad++; $display("FAIL single_valid: got %b want 0100", dout_valid); end
      total++; if (dout !== 8'hA5 || busy !== 1'b1) begin bad++; $display("FAIL single_dout: got %h busy=%b want a5 busy=1", dout, busy); end
      tick();
      total++; if (dout_valid !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL single_idle: got valid=%b busy=%b want 0000/0", dout_valid, busy); end
   endtask

   task automatic test_back_to_back();
      dout_ready = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         din = 8'(i + 1); sel = 2'(i % 4); din_valid = 1'b1;
         sb.push_back({2'(i % 4), 8'(i + 1)});
         total++; if (din_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, din_ready); end
         tick();
         total++; if (dout_valid !== (4'b0001 << (i % 4))) begin bad++; $display("FAIL b2b_onehot[%0d]: got %b want %b", i, dout_valid, 4'b0001 << (i % 4)); end
      end
      din_valid = 1'b0;
      tick();
      total++; if (busy !== 1'b0 || sb.size() != 0) begin bad++; $display("FAIL b2b_drain: got busy=%b owed=%0d want 0/0", busy, sb.size()); end
   endtask

   task automatic test_unselected_ready();
      din = 8'h5E; sel = 2'd0; din_valid = 1'b1; dout_ready = 4'b1110;
      sb.push_back({2'd0, 8'h5E});
      tick();
      din = 8'h99; sel = 2'd3;
      tick(); tick();
      total++; if (din_ready !== 1'b0) begin bad++; $display("FAIL unsel_ready: got %b want 0", din_ready); end
      total++; if (dout_valid !== 4'b0001 || dout !== 8'h5E) begin bad++; $display("FAIL unsel_hold: got valid=%b dout=%h want 0001/5e", dout_valid, dout); end
      din_valid = 1'b0; dout_ready = 4'b0001;
      tick();
      total++; if (busy !== 1'b0 || sb.size() != 0) begin bad++; $display("FAIL unsel_release: got busy=%b owed=%0d want 0/0", busy, sb.size()); end
   endtask

   task automatic test_timeout();
      din = 8'h3C; sel = 2'd1; din_valid = 1'b1; dout_ready = 4'b0000;
      tick();
      din_valid = 1'b0;
      for (int j = 0; j < 15; j++) begin
         total++; if (dout_valid !== 4'b0010 || drop !== 1'b0) begin bad++; $display("FAIL to_hold[%0d]: got valid=%b drop=%b want 0010/0", j, dout_valid, drop); end
         tick();
      end
      total++; if (drop !== 1'b1 || dout_valid !== 4'b0000) begin bad++; $display("FAIL to_drop: got drop=%b valid=%b want 1/0000", drop, dout_valid); end
      dout_ready = 4'b1111;
      tick();
      total++; if (drop !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL to_after: got drop=%b busy=%b want 0/0", drop, busy); end
   endtask

   task automatic test_bad_sel();
      sel3 = 2'd3; din = 8'hC3; din_valid3 = 1'b1; dout_ready3 = 3'b111;
      #1;
      total++; if (din_ready3 !== 1'b1) begin bad++; $display("FAIL bad_ready: got %b want 1", din_ready3); end
      tick();
      din_valid3 = 1'b0;
      total++; if (drop3 !== 1'b1 || dout_valid3 !== 3'b000 || busy3 !== 1'b0) begin bad++; $display("FAIL bad_drop: got drop=%b valid=%b busy=%b want 1/000/0", drop3, dout_valid3, busy3); end
      tick();
      total++; if (drop3 !== 1'b0 || dout_valid3 !== 3'b000) begin bad++; $display("FAIL bad_once: got drop=%b valid=%b want 0/000", drop3, dout_valid3); end
      sel3 = 2'd2; din = 8'h4D; din_valid3 = 1'b1;
      tick();
      din_valid3 = 1'b0;
      total++; if (dout_valid3 !== 3'b100 || dout3 !== 8'h4D) begin bad++; $display("FAIL bad_then_good: got valid=%b dout=%h want 100/4d", dout_valid3, dout3); end
      tick();
   endtask

   task automatic test_reset_hold();
      din = 8'h77; sel = 2'd3; din_valid = 1'b1; dout_ready = 4'b0000;
      tick();
      din_valid = 1'b0;
      total++; if (busy !== 1'b1 || dout_valid !== 4'b1000) begin bad++; $display("FAIL rh_hold: got busy=%b valid=%b want 1/1000", busy, dout_valid); end
      rst_n = 1'b0;
      tick();
      total++; if (dout_valid !== 4'b0000 || busy !== 1'b0 || drop !== 1'b0) begin bad++; $display("FAIL rh_reset: got valid=%b busy=%b drop=%b want 0000/0/0", dout_valid, busy, drop); end
`ifdef DEMUX_STATS_EN
      total++; if (xfer_cnt !== 32'h0 || drop_cnt !== 8'h0) begin bad++; $display("FAIL rh_stats: got xfer=%h drop=%h want 0/0", xfer_cnt, drop_cnt); end
`endif
      rst_n = 1'b1;
      tick();
      total++; if (drop !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rh_nodrop: got drop=%b busy=%b want 0/0", drop, busy); end
      sb.delete();
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_unselected_ready();
      test_timeout();
      test_bad_sel();
      test_reset_hold();
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
